mac_term_sched: RTL and testbench



---
 rtl/mac_sched_pkg.sv | 20 ++
 rtl/mac_mul_unit.sv | 30 +++
 rtl/mac_term_sched.sv | 138 +++++++++++++
 tb/tb_mac_term_sched.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mac_sched_pkg.sv
// Shared types and constants for the shared-multiplier MAC sequencer.
package mac_sched_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StMul,
      StDone
   } state_e;

   // Number of in1 products accumulated per job.
   localparam int unsigned TERM_CNT = 3;

   typedef logic [1:0] idx_t;

   // Accumulator width: holds in5 plus three full-width products without overflow.
   function automatic int unsigned acc_w(input int unsigned w);
      return 2 * w + 2;
   endfunction

endpackage

// File: rtl/mac_mul_unit.sv
// Single shared W x W unsigned multiplier with a 3:1 operand-B select.
module mac_mul_unit
   import mac_sched_pkg::*;
#(
   parameter int unsigned W = 16
) (
   input  logic [W-1:0]   a_i,
   input  logic [W-1:0]   b0_i,
   input  logic [W-1:0]   b1_i,
   input  logic [W-1:0]   b2_i,
   input  logic [1:0]     idx_i,
   output logic [2*W-1:0] prod_o
);

   logic [W-1:0] b_sel;

   // Term index picks which registered operand multiplies in1 this cycle.
   always_comb begin
      b_sel = '0;
      case (idx_i)
         2'd0:    b_sel = b0_i;
         2'd1:    b_sel = b1_i;
         2'd2:    b_sel = b2_i;
         default: b_sel = '0;
      endcase
   end

   assign prod_o = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_sel};

endmodule

// File: rtl/mac_term_sched.sv
// Sequencer computing sum, double difference and MAC with one shared multiplier.
module mac_term_sched
   import mac_sched_pkg::*;
#(
   parameter int unsigned W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [W-1:0]      in1,
   input  logic [W-1:0]      in2,
   input  logic [W-1:0]      in3,
   input  logic [W-1:0]      in4,
   input  logic [W-1:0]      in5,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [W:0]        out1,
   output logic [W:0]        out2,
   output logic [2*W+1:0]    out3,
   output logic              busy
);

   localparam int unsigned AccW = acc_w(W);

   state_e          state_q, state_d;
   idx_t            idx_q, idx_d;
   logic [W-1:0]    op1_q, op1_d;
   logic [W-1:0]    op2_q, op2_d;
   logic [W-1:0]    op3_q, op3_d;
   logic [W-1:0]    op4_q, op4_d;
   logic [AccW-1:0] acc_q, acc_d;
   logic [W:0]      out1_q, out1_d;
   logic [W:0]      out2_q, out2_d;
   logic [AccW-1:0] out3_q, out3_d;
   logic [2*W-1:0]  prod;
   logic [AccW-1:0] acc_sum;

   mac_mul_unit #(
      .W (W)
   ) u_mul (
      .a_i    (op1_q),
      .b0_i   (op4_q),
      .b1_i   (op3_q),
      .b2_i   (op2_q),
      .idx_i  (idx_q),
      .prod_o (prod)
   );

   assign acc_sum = acc_q + AccW'(prod);

   // Next-state: capture on accept, one product per MUL cycle, hold in DONE until taken.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      op1_d   = op1_q;
      op2_d   = op2_q;
      op3_d   = op3_q;
      op4_d   = op4_q;
      acc_d   = acc_q;
      out1_d  = out1_q;
      out2_d  = out2_q;
      out3_d  = out3_q;
      if (clr) begin
         // Abort drops the job but keeps the last visible results.
         state_d = StIdle;
         idx_d   = '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (in_valid) begin
                  op1_d   = in1;
                  op2_d   = in2;
                  op3_d   = in3;
                  op4_d   = in4;
                  out1_d  = {1'b0, in1} + {1'b0, in2};
                  out2_d  = {1'b0, in3} - {1'b0, in2} - {1'b0, in1};
                  acc_d   = AccW'(in5);
                  idx_d   = '0;
                  state_d = StMul;
               end
            end
            StMul: begin
               acc_d = acc_sum;
               idx_d = idx_t'(idx_q + 2'd1);
               if (idx_q == idx_t'(TERM_CNT - 1)) begin
                  // Only the finished sum ever reaches out3.
                  out3_d  = acc_sum;
                  idx_d   = '0;
                  state_d = StDone;
               end
            end
            StDone: begin
               if (out_ready) begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         idx_q   <= '0;
         op1_q   <= '0;
         op2_q   <= '0;
         op3_q   <= '0;
         op4_q   <= '0;
         acc_q   <= '0;
         out1_q  <= '0;
         out2_q  <= '0;
         out3_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         op3_q   <= op3_d;
         op4_q   <= op4_d;
         acc_q   <= acc_d;
         out1_q  <= out1_d;
         out2_q  <= out2_d;
         out3_q  <= out3_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q != StIdle);
   assign out1      = out1_q;
   assign out2      = out2_q;
   assign out3      = out3_q;

endmodule

// File: tb/tb_mac_term_sched.sv
// Directed bench for mac_term_sched with an expected-result queue.
module tb_mac_term_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in1 = '0, in2 = '0, in3 = '0, in4 = '0, in5 = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [16:0] out1, out2;
   logic [33:0] out3;
   logic        busy;

   typedef struct {
      logic [16:0] o1;
      logic [16:0] o2;
      logic [33:0] o3;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   accept_cyc = 0;
   int   prev_accept = 0;
   exp_t last;

   mac_term_sched #(.W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in1       (in1),
      .in2       (in2),
      .in3       (in3),
      .in4       (in4),
      .in5       (in5),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out1      (out1),
      .out2      (out2),
      .out3      (out3),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [15:0] a, b, c, d, e);
      exp_t        r;
      logic [63:0] t;
      t    = 64'(a) + 64'(b);
      r.o1 = t[16:0];
      t    = 64'(c) - 64'(b) - 64'(a);
      r.o2 = t[16:0];
      t    = 64'(e) + 64'(a) * (64'(b) + 64'(c) + 64'(d));
      r.o3 = t[33:0];
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Present one operand set, push its expectation, and take the accepting edge.
   task automatic drive_accept(input logic [15:0] a, b, c, d, e, input bit keep);
      in1 = a; in2 = b; in3 = c; in4 = d; in5 = e;
      in_valid = 1'b1;
      check("in_ready_before_accept", 64'(in_ready), 64'd1);
      q.push_back(model(a, b, c, d, e));
      step();
      prev_accept = accept_cyc;
      accept_cyc  = cyc;
      check("busy_after_accept", 64'(busy), 64'd1);
      if (!keep) begin
         in_valid = 1'b0;
         in1 = 16'($urandom); in2 = 16'($urandom); in3 = 16'($urandom);
         in4 = 16'($urandom); in5 = 16'($urandom);
      end
   endtask

   // Wait (bounded) for out_valid, then compare latency and results with the queue head.
   task automatic collect(output exp_t e);
      int n = 0;
      while (!out_valid && n < 12) begin
         check("in_ready_low_while_busy", 64'(in_ready), 64'd0);
         step();
         n++;
      end
      check("latency", 64'(cyc - accept_cyc), 64'd3);
      if (q.size() == 0) begin
         check("queue_nonempty", 64'd0, 64'd1);
         e = '{default: '0};
      end else begin
         e = q.pop_front();
         check("out1", 64'(out1), 64'(e.o1));
         check("out2", 64'(out2), 64'(e.o2));
         check("out3", 64'(out3), 64'(e.o3));
         check("in_ready_in_done", 64'(in_ready), 64'd0);
      end
   endtask

   initial begin
      exp_t e;
      int   n;

      // Reset values
      #2;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_out1", 64'(out1), 64'd0);
      check("rst_out2", 64'(out2), 64'd0);
      check("rst_out3", 64'(out3), 64'd0);
      #10 rst_n = 1'b1;
      step();

      // Basic job
      out_ready = 1'b1;
      drive_accept(16'd3, 16'd5, 16'd7, 16'd11, 16'd13, 1'b0);
      collect(last);
      step();
      check("basic_out_valid_drop", 64'(out_valid), 64'd0);
      check("basic_in_ready_back", 64'(in_ready), 64'd1);

      // Max operands
      drive_accept(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
      collect(last);
      step();

      // Backpressure with ignored in_valid pulses
      out_ready = 1'b0;
      drive_accept(16'd1234, 16'd4321, 16'd99, 16'd65000, 16'd7, 1'b0);
      collect(last);
      for (int i = 0; i < 10; i++) begin
         in_valid = i[0];
         in1 = 16'($urandom);
         step();
         check("bp_out_valid", 64'(out_valid), 64'd1);
         check("bp_in_ready", 64'(in_ready), 64'd0);
         check("bp_out1", 64'(out1), 64'(last.o1));
         check("bp_out2", 64'(out2), 64'(last.o2));
         check("bp_out3", 64'(out3), 64'(last.o3));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      check("bp_release_valid", 64'(out_valid), 64'd0);
      check("bp_release_ready", 64'(in_ready), 64'd1);
      step();
      check("bp_no_stray_accept", 64'(busy), 64'd0);

      // Back-to-back with in_valid held high
      drive_accept(16'd100, 16'd200, 16'd300, 16'd400, 16'd500, 1'b1);
      in1 = 16'd9; in2 = 16'd8; in3 = 16'd60000; in4 = 16'd5; in5 = 16'd4;
      collect(last);
      n = 0;
      while (!in_ready && n < 12) begin
         step();
         n++;
      end
      drive_accept(16'd9, 16'd8, 16'd60000, 16'd5, 16'd4, 1'b0);
      check("b2b_interval", 64'(accept_cyc - prev_accept), 64'd5);
      collect(last);
      step();

      // clr while the second term is in the multiplier
      drive_accept(16'hAAAA, 16'h5555, 16'h1234, 16'hFFFF, 16'hFFFF, 1'b0);
      void'(q.pop_back());
      step();
      clr = 1'b1;
      step();
      check("clr_busy", 64'(busy), 64'd0);
      check("clr_out_valid", 64'(out_valid), 64'd0);
      check("clr_in_ready", 64'(in_ready), 64'd1);
      check("clr_out3_held", 64'(out3), 64'(last.o3));
      in_valid = 1'b1;
      step();
      check("clr_blocks_accept", 64'(busy), 64'd0);
      in_valid = 1'b0;
      clr = 1'b0;
      for (int i = 0; i < 4; i++) step();
      check("clr_no_out_valid", 64'(out_valid), 64'd0);
      drive_accept(16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 1'b0);
      collect(last);
      step();

      // Asynchronous reset while results are held
      out_ready = 1'b0;
      drive_accept(16'd77, 16'd88, 16'd99, 16'd111, 16'd222, 1'b0);
      collect(last);
      #3 rst_n = 1'b0;
      #1;
      check("arst_out_valid", 64'(out_valid), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_out1", 64'(out1), 64'd0);
      check("arst_out2", 64'(out2), 64'd0);
      check("arst_out3", 64'(out3), 64'd0);
      #1 rst_n = 1'b1;
      step();
      check("arst_in_ready", 64'(in_ready), 64'd1);
      check("queue_drained", 64'(q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
